// File: rtl/friscv_agendador_bombas.sv
// Round-robin scheduler sharing the cup sensor and two juice pumps between two
// requests: latch request, confirm cup via measurement handshake, run a timed dose.
module friscv_agendador_bombas #(
   parameter int TICK_DIV      = 50000,
   parameter int DOSE_TICKS    = 3000,
   parameter int TIMEOUT_TICKS = 100,
   parameter int CNT_W         = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic       pedido_1,
   input  logic       pedido_2,
   input  logic       copo_posicionado,
   input  logic       medida_pronto,
   output logic       inicia_medida,
   output logic       ativa_bomba_1,
   output logic       ativa_bomba_2,
   output logic       pendente_1,
   output logic       pendente_2,
   output logic       ocupado,
   output logic       erro_copo,
   output logic       erro_sensor,
   output logic       fim_dose,
   output logic [3:0] db_estado
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [3:0] {
      INICIAL = 4'b0000,
      ESPERA  = 4'b0001,
      MEDE    = 4'b0010,
      AGUARDA = 4'b0011,
      BOMBA   = 4'b0100,
      FIM     = 4'b0101,
      ERRO    = 4'b0111
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // sel/ultimo encoding: 0 = juice 1, 1 = juice 2
   logic             sel_q, sel_d;
   logic             ultimo_q, ultimo_d;
   logic             pend1_q, pend1_d;
   logic             pend2_q, pend2_d;
   logic             erro_copo_q, erro_copo_d;
   logic             tick, clr_pend, set_err, clr_err;

   assign tick = (presc_q == PW'(TICK_DIV - 1));

   always_comb begin
      estado_d = estado_q;
      sel_d    = sel_q;
      ultimo_d = ultimo_q;
      clr_pend = 1'b0;
      set_err  = 1'b0;
      clr_err  = 1'b0;
      case (estado_q)
         INICIAL: if (habilita) estado_d = ESPERA;
         ESPERA: begin
            if (pend1_q || pend2_q) begin
               estado_d = MEDE;
               sel_d    = (pend1_q && pend2_q) ? ~ultimo_q : pend2_q;
            end
         end
         MEDE:    estado_d = AGUARDA;
         AGUARDA: begin
            if (medida_pronto) begin
               if (copo_posicionado) begin
                  estado_d = BOMBA;
                  clr_err  = 1'b1;
               end else begin
                  estado_d = ESPERA;
                  set_err  = 1'b1;
               end
            end else if (tick && cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
               estado_d = ERRO;
            end
         end
         BOMBA: begin
            if (!copo_posicionado) begin
               estado_d = ESPERA;
               clr_pend = 1'b1;
               set_err  = 1'b1;
               ultimo_d = sel_q;
            end else if (tick && cnt_q == CNT_W'(DOSE_TICKS - 1)) begin
               estado_d = FIM;
            end
         end
         FIM: begin
            estado_d = ESPERA;
            clr_pend = 1'b1;
            ultimo_d = sel_q;
         end
         ERRO:    estado_d = ERRO;
         default: estado_d = INICIAL;
      endcase
      if (!habilita) estado_d = INICIAL;
   end

   // Prescaler and tick counter run only while staying in a timed state,
   // which also clears them on entry to AGUARDA and BOMBA.
   always_comb begin
      presc_d = '0;
      cnt_d   = '0;
      if (estado_d == estado_q && (estado_q == AGUARDA || estado_q == BOMBA)) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         cnt_d   = tick ? cnt_q + CNT_W'(1) : cnt_q;
      end
   end

   // A new request beats a same-cycle clear so it stays queued.
   always_comb begin
      pend1_d = pend1_q;
      pend2_d = pend2_q;
      if (clr_pend && !sel_q) pend1_d = 1'b0;
      if (clr_pend &&  sel_q) pend2_d = 1'b0;
      if (pedido_1) pend1_d = 1'b1;
      if (pedido_2) pend2_d = 1'b1;
      if (!habilita) begin
         pend1_d = 1'b0;
         pend2_d = 1'b0;
      end
      erro_copo_d = erro_copo_q;
      if (pedido_1 || pedido_2 || clr_err) erro_copo_d = 1'b0;
      if (set_err) erro_copo_d = 1'b1;
      if (!habilita) erro_copo_d = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= INICIAL;
         presc_q     <= '0;
         cnt_q       <= '0;
         sel_q       <= 1'b0;
         ultimo_q    <= 1'b1;
         pend1_q     <= 1'b0;
         pend2_q     <= 1'b0;
         erro_copo_q <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         presc_q     <= presc_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         ultimo_q    <= ultimo_d;
         pend1_q     <= pend1_d;
         pend2_q     <= pend2_d;
         erro_copo_q <= erro_copo_d;
      end
   end

   assign inicia_medida = (estado_q == MEDE);
   assign ativa_bomba_1 = (estado_q == BOMBA) && !sel_q;
   assign ativa_bomba_2 = (estado_q == BOMBA) &&  sel_q;
   assign ocupado       = (estado_q == MEDE) || (estado_q == AGUARDA) ||
                          (estado_q == BOMBA) || (estado_q == FIM);
   assign erro_sensor   = (estado_q == ERRO);
   assign fim_dose      = (estado_q == FIM);
   assign pendente_1    = pend1_q;
   assign pendente_2    = pend2_q;
   assign erro_copo     = erro_copo_q;

   always_comb begin
      case (estado_q)
         INICIAL, ESPERA, MEDE, AGUARDA, BOMBA, FIM, ERRO: db_estado = estado_q;
         default: db_estado = 4'b1110;
      endcase
   end

endmodule

// File: tb/tb_friscv_agendador_bombas.sv
// Directed bench for the pump scheduler with small timing parameters
// (4 cycles per tick, 3-tick dose, 2-tick sensor timeout).
module tb_friscv_agendador_bombas;

   logic       clock = 1'b0;
   logic       reset, habilita, pedido_1, pedido_2, copo_posicionado, medida_pronto;
   logic       inicia_medida, ativa_bomba_1, ativa_bomba_2, pendente_1, pendente_2;
   logic       ocupado, erro_copo, erro_sensor, fim_dose;
   logic [3:0] db_estado;

   int n_vec = 0;
   int n_err = 0;

   friscv_agendador_bombas #(
      .TICK_DIV(4), .DOSE_TICKS(3), .TIMEOUT_TICKS(2), .CNT_W(16)
   ) dut (
      .clock(clock), .reset(reset), .habilita(habilita),
      .pedido_1(pedido_1), .pedido_2(pedido_2),
      .copo_posicionado(copo_posicionado), .medida_pronto(medida_pronto),
      .inicia_medida(inicia_medida), .ativa_bomba_1(ativa_bomba_1),
      .ativa_bomba_2(ativa_bomba_2), .pendente_1(pendente_1), .pendente_2(pendente_2),
      .ocupado(ocupado), .erro_copo(erro_copo), .erro_sensor(erro_sensor),
      .fim_dose(fim_dose), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [12:0] all_out();
      return {inicia_medida, ativa_bomba_1, ativa_bomba_2, pendente_1, pendente_2,
              ocupado, erro_copo, erro_sensor, fim_dose, db_estado};
   endfunction

   task automatic do_reset();
      reset = 1'b1; habilita = 1'b0; pedido_1 = 1'b0; pedido_2 = 1'b0;
      medida_pronto = 1'b0; copo_posicionado = 1'b1;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic pedir(input logic p1, input logic p2);
      pedido_1 = p1; pedido_2 = p2;
      step();
      pedido_1 = 1'b0; pedido_2 = 1'b0;
   endtask

   // From ESPERA with a request pending: MEDE, two AGUARDA cycles, then the result.
   task automatic measure(input logic copo_v);
      step();
      chk("mede_db", db_estado, 4'd2);
      chk("mede_inicia", inicia_medida, 1'b1);
      chk("mede_ocupado", ocupado, 1'b1);
      step();
      chk("aguarda_db", db_estado, 4'd3);
      chk("aguarda_inicia", inicia_medida, 1'b0);
      step();
      medida_pronto = 1'b1; copo_posicionado = copo_v;
      step();
      medida_pronto = 1'b0; copo_posicionado = 1'b1;
   endtask

   // From the first BOMBA cycle: count pump cycles, check FIM and the return to ESPERA.
   task automatic dose(input int exp_pump, input logic requeue);
      int n1, n2, both, g;
      n1 = 0; n2 = 0; both = 0; g = 0;
      chk("bomba_db", db_estado, 4'd4);
      while (db_estado == 4'd4 && g < 40) begin
         if (ativa_bomba_1) n1++;
         if (ativa_bomba_2) n2++;
         if (ativa_bomba_1 && ativa_bomba_2) both++;
         step();
         g++;
      end
      chk("dose_b1", n1, (exp_pump == 1) ? 12 : 0);
      chk("dose_b2", n2, (exp_pump == 2) ? 12 : 0);
      chk("dose_both", both, 0);
      chk("fim_db", db_estado, 4'd5);
      chk("fim_pulse", fim_dose, 1'b1);
      if (requeue) begin
         if (exp_pump == 1) pedido_1 = 1'b1; else pedido_2 = 1'b1;
      end
      step();
      pedido_1 = 1'b0; pedido_2 = 1'b0;
      chk("pos_fim_db", db_estado, 4'd1);
      chk("pos_fim_pulse", fim_dose, 1'b0);
      chk("pos_fim_pend", (exp_pump == 1) ? pendente_1 : pendente_2, requeue);
   endtask

   initial begin
      reset = 1'b1; habilita = 1'b0; pedido_1 = 1'b0; pedido_2 = 1'b0;
      medida_pronto = 1'b0; copo_posicionado = 1'b1;

      // single request
      do_reset();
      chk("reset_outs", all_out(), 13'd0);
      habilita = 1'b1;
      step();
      chk("espera_db", db_estado, 4'd1);
      pedir(1'b1, 1'b0);
      chk("pend1_set", pendente_1, 1'b1);
      chk("still_espera", db_estado, 4'd1);
      measure(1'b1);
      dose(1, 1'b0);

      // round robin: juice 1 wins the first tie, then alternation
      do_reset();
      habilita = 1'b1;
      step();
      pedir(1'b1, 1'b1);
      chk("rr_pend", {pendente_1, pendente_2}, 2'b11);
      measure(1'b1);
      dose(1, 1'b0);
      chk("rr_pend2_kept", pendente_2, 1'b1);
      measure(1'b1);
      dose(2, 1'b0);
      pedir(1'b1, 1'b1);
      measure(1'b1);
      dose(1, 1'b0);
      measure(1'b1);
      dose(2, 1'b0);

      // no cup, retry, then a request re-queued in the FIM cycle
      do_reset();
      habilita = 1'b1;
      step();
      pedir(1'b1, 1'b0);
      measure(1'b0);
      chk("nocup_db", db_estado, 4'd1);
      chk("nocup_err", erro_copo, 1'b1);
      chk("nocup_pend", pendente_1, 1'b1);
      measure(1'b1);
      chk("retry_err_clr", erro_copo, 1'b0);
      dose(1, 1'b1);

      // cup removed in the 5th BOMBA cycle (pending request from the re-queue)
      measure(1'b1);
      repeat (4) step();
      chk("rm_pump_on", ativa_bomba_1, 1'b1);
      copo_posicionado = 1'b0;
      step();
      copo_posicionado = 1'b1;
      chk("rm_pump_off", ativa_bomba_1, 1'b0);
      chk("rm_db", db_estado, 4'd1);
      chk("rm_pend", pendente_1, 1'b0);
      chk("rm_err", erro_copo, 1'b1);
      chk("rm_fim", fim_dose, 1'b0);
      step();
      chk("rm_idle", db_estado, 4'd1);

      // sensor timeout; new request also clears erro_copo
      pedir(1'b1, 1'b0);
      chk("ped_clr_err", erro_copo, 1'b0);
      step();
      chk("to_mede", db_estado, 4'd2);
      step();
      repeat (7) step();
      chk("to_aguarda8", db_estado, 4'd3);
      step();
      chk("to_erro_db", db_estado, 4'd7);
      chk("to_erro_sensor", erro_sensor, 1'b1);
      chk("to_ocupado", ocupado, 1'b0);
      step();
      chk("to_erro_hold", db_estado, 4'd7);
      habilita = 1'b0;
      step();
      chk("dis_outs", all_out(), 13'd0);

      // async reset between edges while pump 2 runs
      habilita = 1'b1;
      step();
      pedir(1'b0, 1'b1);
      measure(1'b1);
      step(); step();
      chk("ar_pump2_on", ativa_bomba_2, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("ar_pump2_off", ativa_bomba_2, 1'b0);
      chk("ar_db", db_estado, 4'd0);
      chk("ar_pend2", pendente_2, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/friscv_agendador_bombas.md
Name: friscv_agendador_bombas

Overview:
Scheduler that shares the cup-position sensor and the two juice pumps between two juice requests. It latches requests from the juice buttons and picks one with round-robin priority. It confirms the cup through a measurement handshake with the sensor block, then runs the selected pump for a timed dose. It sits between the button/debounce logic and the pump drivers, and replaces direct button-to-pump control.

Parameters:
TICK_DIV, 50000, clock cycles per time tick (1 ms at 50 MHz); must be >= 2.
DOSE_TICKS, 3000, ticks a pump stays on for one full dose.
TIMEOUT_TICKS, 100, ticks allowed for medida_pronto after a measurement is started.
CNT_W, 16, width of tick and dose counters; must hold max(DOSE_TICKS, TIMEOUT_TICKS).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
habilita  in  1  system enable (liga); low forces idle
pedido_1  in  1  request for juice 1, one-cycle pulse
pedido_2  in  1  request for juice 2, one-cycle pulse
copo_posicionado  in  1  cup present (level); valid when medida_pronto=1, monitored continuously while pumping
medida_pronto  in  1  sensor measurement complete, one-cycle pulse
inicia_medida  out  1  start sensor measurement, one-cycle pulse
ativa_bomba_1  out  1  pump 1 on
ativa_bomba_2  out  1  pump 2 on
pendente_1  out  1  juice 1 request pending
pendente_2  out  1  juice 2 request pending
ocupado  out  1  a request is being served (states MEDE..FIM)
erro_copo  out  1  sticky: last attempt found no cup or the cup was removed
erro_sensor  out  1  measurement timeout, held while in ERRO
fim_dose  out  1  one-cycle pulse when a full dose completes
db_estado  out  4  state code, debug

Behaviour:
- Reset: state INICIAL. All outputs 0. db_estado=0000. Pending flags, erro_copo and counters cleared. ultimo=2, so juice 1 wins the first tie.
- Outputs are Moore and decoded from the state register, except the pending and erro_copo registers.
- States and codes:
  - INICIAL 0000: goes to ESPERA when habilita=1.
  - ESPERA 0001: if pendente_1 or pendente_2, go to MEDE and latch the served id `sel`. When both are pending, `sel` = the id that is not `ultimo`.
  - MEDE 0010: inicia_medida=1 for exactly 1 cycle, then go to AGUARDA.
  - AGUARDA 0011: waits for medida_pronto.
    - medida_pronto=1 and copo_posicionado=1: go to BOMBA and clear erro_copo.
    - medida_pronto=1 and copo_posicionado=0: set erro_copo, go to ESPERA; the request stays pending and is retried.
    - No medida_pronto within TIMEOUT_TICKS ticks: go to ERRO.
  - BOMBA 0100: ativa_bomba_<sel>=1. The tick prescaler and dose counter are cleared on entry.
    - Uninterrupted, the pump stays on for exactly DOSE_TICKS*TICK_DIV cycles, then the state goes to FIM.
    - If copo_posicionado=0 in any BOMBA cycle, the next state is ESPERA: pump off on the next edge, pendente_<sel> cleared, erro_copo=1, ultimo=sel, no fim_dose.
  - FIM 0101: fim_dose=1 for 1 cycle; pendente_<sel> cleared; ultimo=sel; go to ESPERA.
  - ERRO 0111: erro_sensor=1; pumps off. Left only by reset or habilita=0.
  - Unused codes: db_estado=1110, next state INICIAL.
- habilita=0 in any state: next state INICIAL; pumps off from the next edge; pending flags and erro_copo cleared.
- Pending flags:
  - pedido_k with habilita=1 sets pendente_k on the next edge, in any state.
  - A pulse while pendente_k=1 has no effect (no counting).
  - If a set and a clear of the same flag occur in the same cycle, the set wins and a new request is queued.
- erro_copo is also cleared by any new pedido_1 or pedido_2.
- Only one pump is ever on. ativa_bomba_1 & ativa_bomba_2 is always 0.
- Counters saturate-free: the prescaler wraps at TICK_DIV-1 and is cleared on entry to AGUARDA and BOMBA. Timeout and dose counters count prescaler wraps only.

Test Plan:
(Test parameters: TICK_DIV=4, DOSE_TICKS=3, TIMEOUT_TICKS=2.)
- Single request: reset, habilita=1, pedido_1 pulse, medida_pronto with copo=1 two cycles after inicia_medida → ativa_bomba_1 high exactly 12 cycles; then fim_dose pulses once, pendente_1=0, db_estado sequence 1,2,3,4,5,1.
- Round-robin: pedido_1 and pedido_2 in the same cycle → pump 1 dose, then pump 2 dose. Requeue both → pump 2 is not repeated first; pump 1 serves first again, since ultimo=2 after the second dose.
- No cup: medida_pronto with copo=0 → erro_copo=1, pendente_1 stays 1, state returns to ESPERA and inicia_medida pulses again. The next measurement with copo=1 → dose runs and erro_copo clears.
- Cup removed mid-dose: copo drops in the 5th BOMBA cycle → ativa_bomba_1=0 on the next edge, pendente_1=0, erro_copo=1, fim_dose never asserted.
- Sensor timeout: no medida_pronto for 8 cycles after AGUARDA entry → state ERRO (0111), erro_sensor=1. Then habilita=0 → INICIAL, all outputs 0.
- Async reset asserted mid-BOMBA, between clock edges → pump outputs drop immediately, db_estado=0000, pending flags cleared.
